// File: rtl/branch_unit_if.sv
// Decode/fetch-facing signal bundle of the branch unit.
// slave: the branch unit itself; master: the decode/fetch side driving it.
interface branch_unit_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4,
    parameter int CNT_W  = 8
);
    // Decode side
    logic              Hold;
    logic              BrValid;
    logic [2:0]        BrOp;
    logic [LUT_AW-1:0] LutIdx;
    logic              ZeroFlag;
    logic              NegFlag;
    logic [PC_W-1:0]   ProgCtr;

    // LUT programming port
    logic              LutWe;
    logic [LUT_AW-1:0] LutWAddr;
    logic [PC_W-1:0]   LutWData;

    // Fetch redirect
    logic              Jump;
    logic              BranchAbsOrRel;
    logic [PC_W-1:0]   Target;

    // Status
    logic              RasFull;
    logic              RasEmpty;
    logic              Fault;
    logic [CNT_W-1:0]  TakenCnt;

    modport master (
        output Hold, BrValid, BrOp, LutIdx, ZeroFlag, NegFlag, ProgCtr,
        output LutWe, LutWAddr, LutWData,
        input  Jump, BranchAbsOrRel, Target,
        input  RasFull, RasEmpty, Fault, TakenCnt
    );

    modport slave (
        input  Hold, BrValid, BrOp, LutIdx, ZeroFlag, NegFlag, ProgCtr,
        input  LutWe, LutWAddr, LutWData,
        output Jump, BranchAbsOrRel, Target,
        output RasFull, RasEmpty, Fault, TakenCnt
    );
endinterface

// File: rtl/branch_unit.sv
// Control-flow resolution between decode and fetch: branch-target LUT,
// return-address stack, sticky fault flag and saturating taken counter.
// Redirect outputs are combinational (zero latency); state commits on the
// same posedge at which fetch samples the redirect.
module branch_unit #(
    parameter int PC_W      = 10,
    parameter int LUT_AW    = 4,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 8
) (
    input logic          Clk,
    input logic          Reset,
    branch_unit_if.slave bus
);

    localparam int SP_W = $clog2(RAS_DEPTH + 1);
    localparam int RA_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_JMP  = 3'b000,
        OP_BZ   = 3'b001,
        OP_BNZ  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_BN   = 3'b101,
        OP_IL6  = 3'b110,
        OP_IL7  = 3'b111
    } br_op_e;

    logic [PC_W-1:0]  lut [2**LUT_AW];
    logic [PC_W-1:0]  ras [RAS_DEPTH];
    logic [SP_W-1:0]  sp;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;

    br_op_e           op;
    logic             act;
    logic             ras_full;
    logic             ras_empty;
    logic [RA_W-1:0]  push_idx;
    logic [RA_W-1:0]  top_idx;
    logic [PC_W-1:0]  lut_rd;
    logic [PC_W-1:0]  ras_top;
    logic [PC_W-1:0]  ret_addr;

    logic             jump;
    logic             rel;
    logic [PC_W-1:0]  tgt;
    logic             push;
    logic             pop;
    logic             fault_set;

    assign op        = br_op_e'(bus.BrOp);
    assign act       = bus.BrValid & ~bus.Hold & ~Reset;
    assign ras_full  = (sp == SP_W'(RAS_DEPTH));
    assign ras_empty = (sp == '0);
    assign push_idx  = RA_W'(sp);
    assign top_idx   = RA_W'(sp - 1'b1);
    assign lut_rd    = lut[bus.LutIdx];
    assign ras_top   = ras[top_idx];
    assign ret_addr  = bus.ProgCtr + 1'b1;

    // Decode the op into redirect outputs and the state updates it commits
    always_comb begin
        jump      = 1'b0;
        rel       = 1'b0;
        tgt       = '0;
        push      = 1'b0;
        pop       = 1'b0;
        fault_set = 1'b0;
        if (act) begin
            case (op)
                OP_JMP: begin
                    jump = 1'b1;
                    tgt  = lut_rd;
                end
                OP_BZ: begin
                    if (bus.ZeroFlag) begin
                        jump = 1'b1;
                        rel  = 1'b1;
                        tgt  = lut_rd;
                    end
                end
                OP_BNZ: begin
                    if (!bus.ZeroFlag) begin
                        jump = 1'b1;
                        rel  = 1'b1;
                        tgt  = lut_rd;
                    end
                end
                OP_BN: begin
                    if (bus.NegFlag) begin
                        jump = 1'b1;
                        rel  = 1'b1;
                        tgt  = lut_rd;
                    end
                end
                OP_CALL: begin
                    if (ras_full) begin
                        fault_set = 1'b1;
                    end else begin
                        jump = 1'b1;
                        tgt  = lut_rd;
                        push = 1'b1;
                    end
                end
                OP_RET: begin
                    if (ras_empty) begin
                        fault_set = 1'b1;
                    end else begin
                        jump = 1'b1;
                        tgt  = ras_top;
                        pop  = 1'b1;
                    end
                end
                default: begin
                    fault_set = 1'b1;
                end
            endcase
        end
    end

    assign bus.Jump           = jump;
    assign bus.BranchAbsOrRel = rel;
    assign bus.Target         = tgt;
    // Status is forced to the post-reset view while Reset is held
    assign bus.RasEmpty       = Reset | ras_empty;
    assign bus.RasFull        = ~Reset & ras_full;
    assign bus.Fault          = fault_q;
    assign bus.TakenCnt       = cnt_q;

    // Target LUT: cleared by reset, otherwise written from the programming port
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lut <= '{default: '0};
        end else if (bus.LutWe) begin
            lut[bus.LutWAddr] <= bus.LutWData;
        end
    end

    // Return-address stack entries and pointer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ras <= '{default: '0};
            sp  <= '0;
        end else if (push) begin
            ras[push_idx] <= ret_addr;
            sp            <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end

    // Sticky fault flag and saturating taken-redirect counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (fault_set) begin
                fault_q <= 1'b1;
            end
            if (jump && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: the stimulus process queues the expected
// redirect and status for each checked cycle; the monitor pops and compares
// mid-cycle whenever a checked cycle is presented.
module tb_branch_unit;

    localparam logic [2:0] JMP = 3'b000, BZ = 3'b001, BNZ = 3'b010,
                           CALL = 3'b011, RET = 3'b100, BN = 3'b101;

    typedef struct {
        logic       j;
        logic       rel;
        logic [9:0] tgt;
        logic       full;
        logic       empty;
        logic       fault;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic probe;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    branch_unit_if #(.PC_W(10), .LUT_AW(4), .CNT_W(8)) bif ();

    branch_unit #(
        .PC_W     (10),
        .LUT_AW   (4),
        .RAS_DEPTH(4),
        .CNT_W    (8)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents on a checked cycle
    always @(negedge clk) begin
        if (probe) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk(e.name, "Jump",     32'(bif.Jump),           32'(e.j));
                chk(e.name, "AbsRel",   32'(bif.BranchAbsOrRel), 32'(e.rel));
                chk(e.name, "Target",   32'(bif.Target),         32'(e.tgt));
                chk(e.name, "RasFull",  32'(bif.RasFull),        32'(e.full));
                chk(e.name, "RasEmpty", 32'(bif.RasEmpty),       32'(e.empty));
                chk(e.name, "Fault",    32'(bif.Fault),          32'(e.fault));
                chk(e.name, "TakenCnt", 32'(bif.TakenCnt),       32'(e.cnt));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        bif.BrValid = 1'b0;
        bif.Hold    = 1'b0;
        bif.LutWe   = 1'b0;
        probe       = 1'b0;
    endtask

    task automatic dec(input logic v, input logic [2:0] op, input logic [3:0] idx,
                       input logic z, input logic n, input logic [9:0] pc);
        bif.BrValid  = v;
        bif.BrOp     = op;
        bif.LutIdx   = idx;
        bif.ZeroFlag = z;
        bif.NegFlag  = n;
        bif.ProgCtr  = pc;
    endtask

    task automatic lutw(input logic [3:0] a, input logic [9:0] d);
        bif.LutWe    = 1'b1;
        bif.LutWAddr = a;
        bif.LutWData = d;
    endtask

    task automatic expect_now(input logic j, input logic rel, input logic [9:0] tgt,
                              input logic full, input logic empty, input logic fault,
                              input logic [7:0] cnt, input string name);
        exp_t e;
        e.j = j; e.rel = rel; e.tgt = tgt; e.full = full; e.empty = empty;
        e.fault = fault; e.cnt = cnt; e.name = name;
        q.push_back(e);
        probe = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        probe = 1'b0;
        bif.Hold = 1'b0;
        bif.LutWe = 1'b0;
        bif.LutWAddr = '0;
        bif.LutWData = '0;
        dec(0, JMP, 0, 0, 0, 0);
        tick;

        // Reset held: outputs idle, LUT write ignored
        dec(1, JMP, 0, 0, 0, 0);
        lutw(2, 10'h155);
        expect_now(0, 0, 10'h000, 0, 1, 0, 0, "rst_outputs");
        tick;
        rst = 1'b0;

        lutw(3, 10'h120); tick;
        dec(1, JMP, 3, 0, 0, 0);
        expect_now(1, 0, 10'h120, 0, 1, 0, 0, "jmp_abs"); tick;
        dec(1, JMP, 2, 0, 0, 0);
        expect_now(1, 0, 10'h000, 0, 1, 0, 1, "lut_wr_in_reset"); tick;

        lutw(5, 10'h3FE); tick;
        dec(1, BZ, 5, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 2, "bz_not_taken"); tick;
        dec(1, BZ, 5, 1, 0, 0);
        expect_now(1, 1, 10'h3FE, 0, 1, 0, 2, "bz_taken"); tick;
        dec(1, BNZ, 5, 0, 0, 0);
        expect_now(1, 1, 10'h3FE, 0, 1, 0, 3, "bnz_taken"); tick;
        dec(1, BNZ, 5, 1, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 4, "bnz_not_taken"); tick;
        dec(1, BN, 5, 0, 1, 0);
        expect_now(1, 1, 10'h3FE, 0, 1, 0, 4, "bn_taken"); tick;
        dec(1, BN, 5, 1, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 5, "bn_not_taken"); tick;

        // Same-index read and write: read returns the old value
        dec(1, JMP, 5, 0, 0, 0);
        lutw(5, 10'h0AA);
        expect_now(1, 0, 10'h3FE, 0, 1, 0, 5, "lut_rd_during_wr"); tick;
        dec(1, JMP, 5, 0, 0, 0);
        expect_now(1, 0, 10'h0AA, 0, 1, 0, 6, "lut_rd_after_wr"); tick;

        // CALL at the top of the address space wraps the return address
        lutw(1, 10'h040); tick;
        dec(1, CALL, 1, 0, 0, 10'h3FF);
        expect_now(1, 0, 10'h040, 0, 1, 0, 7, "call_wrap"); tick;
        dec(1, RET, 0, 0, 0, 0);
        expect_now(1, 0, 10'h000, 0, 0, 0, 8, "ret_wrap"); tick;
        dec(0, JMP, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 9, "ret_popped"); tick;

        // RET on empty stack faults; fault is sticky
        dec(1, RET, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 9, "ret_empty"); tick;
        dec(1, JMP, 3, 0, 0, 0);
        expect_now(1, 0, 10'h120, 0, 1, 1, 9, "fault_sticky"); tick;
        dec(0, JMP, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 1, 10, "fault_sticky2"); tick;

        rst = 1'b1;
        dec(1, RET, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 1, 10, "reset_cycle"); tick;
        rst = 1'b0;
        dec(0, JMP, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 0, "post_reset"); tick;

        // Fill the stack, overflow, then unwind
        lutw(1, 10'h040); tick;
        for (int k = 0; k < 4; k++) begin
            dec(1, CALL, 1, 0, 0, 10'(10'h010 + k));
            expect_now(1, 0, 10'h040, 0, (k == 0), 0, 8'(k), "call_fill"); tick;
        end
        dec(1, CALL, 1, 0, 0, 10'h014);
        expect_now(0, 0, 10'h000, 1, 0, 0, 4, "call_full"); tick;
        dec(0, JMP, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 1, 0, 1, 4, "call_full_fault"); tick;
        for (int j = 0; j < 4; j++) begin
            dec(1, RET, 0, 0, 0, 0);
            expect_now(1, 0, 10'(10'h014 - j), (j == 0), 0, 1, 8'(4 + j), "ret_order"); tick;
        end

        // Hold suppresses the op; it is re-presented afterwards
        dec(1, CALL, 1, 0, 0, 10'h100);
        bif.Hold = 1'b1;
        expect_now(0, 0, 10'h000, 0, 1, 1, 8, "hold_call"); tick;
        dec(0, JMP, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 1, 8, "hold_no_state"); tick;
        dec(1, CALL, 1, 0, 0, 10'h100);
        expect_now(1, 0, 10'h040, 0, 1, 1, 8, "call_after_hold"); tick;
        dec(1, CALL, 1, 0, 0, 10'h200);
        expect_now(1, 0, 10'h040, 0, 0, 1, 9, "call_second"); tick;

        // Reset with two entries pushed discards them
        rst = 1'b1;
        dec(1, RET, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 1, 10, "reset_with_ras"); tick;
        rst = 1'b0;
        dec(1, RET, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 0, "ret_after_reset"); tick;
        dec(1, JMP, 1, 0, 0, 0);
        expect_now(1, 0, 10'h000, 0, 1, 1, 0, "lut_cleared"); tick;

        rst = 1'b1; tick;
        rst = 1'b0;
        dec(1, RET, 0, 0, 0, 0);
        bif.Hold = 1'b1;
        expect_now(0, 0, 10'h000, 0, 1, 0, 0, "hold_ret_empty"); tick;
        dec(0, JMP, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 0, "hold_no_fault"); tick;
        dec(1, 3'b110, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 0, 0, "illegal_op"); tick;
        dec(1, 3'b111, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 1, 0, "illegal_fault"); tick;

        // Counter saturation
        for (int k = 0; k < 260; k++) begin
            dec(1, JMP, 0, 0, 0, 0);
            expect_now(1, 0, 10'h000, 0, 1, 1, (k > 255) ? 8'hFF : 8'(k), "cnt_sat"); tick;
        end
        dec(0, JMP, 0, 0, 0, 0);
        expect_now(0, 0, 10'h000, 0, 1, 1, 8'hFF, "cnt_sat_hold"); tick;

        tick;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Control-flow resolution block for the 9-bit ISA core. It sits between decode and instruction fetch and drives the fetch unit's Jump, BranchAbsOrRel and Target inputs. It holds a programmable branch-target lookup table (LUT), a 4-entry return-address stack (RAS) for CALL/RET, a sticky fault flag, and a saturating taken-branch counter.

## Interface
- PC_W, 10, program-counter / target width
- LUT_AW, 4, LUT index width (16 entries)
- RAS_DEPTH, 4, return-stack entries
- CNT_W, 8, taken-branch counter width

- Clk  in  1  clock; all state changes on posedge
- Reset  in  1  synchronous, active-high
- Hold  in  1  fetch is held (same signal as fetch Start); suppresses all control flow
- BrValid  in  1  the decoded instruction this cycle is control-flow
- BrOp  in  3  000 JMP, 001 BZ, 010 BNZ, 011 CALL, 100 RET, 101 BN; 110/111 illegal
- LutIdx  in  LUT_AW  LUT entry selected by the instruction
- ZeroFlag, NegFlag  in  1 each  registered ALU flags
- ProgCtr  in  PC_W  current PC from fetch
- LutWe  in  1  LUT write enable
- LutWAddr  in  LUT_AW  LUT write address
- LutWData  in  PC_W  LUT write data
- Jump  out  1  to fetch: redirect this cycle
- BranchAbsOrRel  out  1  to fetch: 0 = absolute, 1 = relative (Target is a two's-complement offset)
- Target  out  PC_W  to fetch: address or offset
- RasFull, RasEmpty  out  1 each  stack status, decoded from registered pointer
- Fault  out  1  sticky error flag
- TakenCnt  out  CNT_W  saturating count of taken redirects

## Operation
- LUT: 16 x PC_W registers, written at posedge when LutWe=1. The LUT read is asynchronous and returns the pre-write value when read and write hit the same index in the same cycle.
- Condition "act": BrValid=1, Hold=0, Reset=0. Without act, Jump=0 and no state changes except LUT writes.
- JMP: Jump=1, Abs, Target=LUT[LutIdx].
- BZ / BNZ / BN:
  - Branch is taken when ZeroFlag=1 / ZeroFlag=0 / NegFlag=1 respectively.
  - Taken: Jump=1, Rel, Target=LUT[LutIdx] used as a signed offset. Fetch adds modulo 2^PC_W.
  - Not taken: Jump=0.
- CALL:
  - If the RAS is not full: Jump=1, Abs, Target=LUT[LutIdx]; push (ProgCtr+1) mod 2^PC_W.
  - If full: Jump=0, no push, Fault set.
- RET:
  - If the RAS is not empty: Jump=1, Abs, Target=top entry; pop.
  - If empty: Jump=0, Fault set.
- Illegal BrOp with act: Jump=0, Fault set.
- RAS:
  - Pointer sp ranges 0..RAS_DEPTH. RasEmpty = (sp==0); RasFull = (sp==RAS_DEPTH).
  - Push writes entry[sp] and increments sp. Pop decrements sp.
  - Top entry is entry[sp-1].
  - Push and pop cannot occur in the same cycle (one op per cycle).
- TakenCnt increments by 1 on every cycle with Jump=1 and saturates at 2^CNT_W-1.
- Fault stays at 1 until Reset.
- When Jump=0, BranchAbsOrRel=0 and Target=0 (deterministic idle outputs).

## Timing
- Jump, BranchAbsOrRel and Target are combinational from the current inputs plus registered LUT/RAS state. Fetch samples them at the same posedge at which this block commits its push/pop/counter/Fault updates. There are zero cycles of latency.
- Reset (at posedge):
  - sp=0, Fault=0, TakenCnt=0, all LUT and RAS entries=0.
  - While Reset=1: Jump=0, BranchAbsOrRel=0, Target=0, RasEmpty=1, RasFull=0. LUT writes are ignored.
- Reset asserted with the RAS partly filled discards all entries. A RET in the first cycle after reset faults.
- Hold=1 suppresses the op entirely: no push/pop, no Fault, no count. The same op is re-presented when Hold drops.
- Status outputs (RasFull, RasEmpty, Fault, TakenCnt) reflect registered state. Updates are visible the cycle after the causing op.
- Back-to-back CALL then RET on consecutive cycles: the RET sees the pushed value.

## Test plan
- Write LUT[3]=0x120, then JMP idx 3 with act -> Jump=1, BranchAbsOrRel=0, Target=0x120; TakenCnt=1 the next cycle.
- LUT[5]=0x3FE; BZ idx 5 with ZeroFlag=0 -> Jump=0. Repeat with ZeroFlag=1 -> Jump=1, BranchAbsOrRel=1, Target=0x3FE. BN with NegFlag=1 -> same result.
- LUT[1]=0x040; CALL idx 1 at ProgCtr=0x3FF -> Target=0x040; the next cycle RasEmpty=0. RET -> Jump=1, Abs, Target=0x000, and RasEmpty=1 afterwards.
- Five CALLs at PCs 0x010..0x014 -> the first four jump and RasFull=1 after them. The fifth gives Jump=0 and Fault=1. Four RETs then return Targets 0x014, 0x013, 0x012, 0x011 in that order.
- RET with an empty stack -> Jump=0, Fault=1. Fault stays 1 through later valid ops until Reset.
- Hold=1 during CALL -> Jump=0 with sp and TakenCnt unchanged. Push two entries, assert Reset -> RasEmpty=1, Fault=0, TakenCnt=0, and LUT reads return 0.
